// File: rtl/if_row_sender.sv
// Streams IF rows from the IF buffer SRAM into a PE input-feature pad, one pixel per beat.
// A 2-entry skid FIFO with bypass absorbs the 1-cycle SRAM read latency.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for i_start; config sampled on the start edge
// ISSUE  | issuing buffer reads, gated by FIFO credit
// DRAIN  | all reads issued; waiting for FIFO and in-flight read to empty
module if_row_sender #(
   parameter int DWd     = 16,
   parameter int AddrWd  = 10,
   parameter int ConfDWd = 4,
   parameter int RowWd   = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [AddrWd-1:0]  i_base,
   input  logic [AddrWd-1:0]  i_stride,
   input  logic [ConfDWd-1:0] i_iflen,
   input  logic [RowWd-1:0]   i_nrow,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_buf_ren,
   output logic [AddrWd-1:0]  o_buf_raddr,
   input  logic [DWd-1:0]     i_buf_rdata,
   output logic [DWd-1:0]     o_ipix_wdata,
   output logic               o_ipix_valid,
   input  logic               i_ipix_ready,
   output logic               o_ipix_last
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   done_d, done_q;

   logic [AddrWd-1:0]  stride_q;
   logic [AddrWd-1:0]  row_base_q;
   logic [ConfDWd-1:0] iflen_q;
   logic [ConfDWd-1:0] col_q;
   logic [RowWd-1:0]   rows_left_q;

   logic               rd_pend_q;
   logic               rd_last_q;

   logic [DWd-1:0]     fifo_data_q [2];
   logic               fifo_last_q [2];
   logic               wr_ptr_q;
   logic               rd_ptr_q;
   logic [1:0]         cnt_q;

   logic               fifo_empty;
   logic               valid;
   logic [DWd-1:0]     head_data;
   logic               head_last;
   logic               pop;
   logic               push_fifo;
   logic               pop_fifo;
   logic [2:0]         occ_after;
   logic               issue;
   logic               col_end;
   logic               row_end;

   // Head comes from the FIFO when it holds data, otherwise straight from the returning read.
   always_comb begin
      fifo_empty = (cnt_q == 2'd0);
      valid      = !fifo_empty || rd_pend_q;
      head_data  = fifo_empty ? i_buf_rdata : fifo_data_q[rd_ptr_q];
      head_last  = fifo_empty ? rd_last_q   : fifo_last_q[rd_ptr_q];
      pop        = valid && i_ipix_ready;
      push_fifo  = rd_pend_q && !(fifo_empty && pop);
      pop_fifo   = pop && !fifo_empty;
      occ_after  = 3'(cnt_q) + 3'(rd_pend_q) - 3'(pop);
      issue      = (state_q == S_ISSUE) && (occ_after < 3'd2);
      col_end    = (col_q == iflen_q - ConfDWd'(1));
      row_end    = (rows_left_q == RowWd'(1));
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               if ((i_iflen == '0) || (i_nrow == '0)) state_d = S_DRAIN;
               else                                   state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (issue && col_end && row_end) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (occ_after == 3'd0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stride_q    <= '0;
         row_base_q  <= '0;
         iflen_q     <= '0;
         col_q       <= '0;
         rows_left_q <= '0;
      end else if ((state_q == S_IDLE) && i_start) begin
         stride_q    <= i_stride;
         row_base_q  <= i_base;
         iflen_q     <= i_iflen;
         col_q       <= '0;
         rows_left_q <= i_nrow;
      end else if (issue) begin
         if (col_end) begin
            col_q       <= '0;
            row_base_q  <= row_base_q + stride_q;
            rows_left_q <= rows_left_q - RowWd'(1);
         end else begin
            col_q <= col_q + ConfDWd'(1);
         end
      end
   end

   // Clearing rd_pend_q on reset drops any read return still in flight.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rd_pend_q <= 1'b0;
         rd_last_q <= 1'b0;
      end else begin
         rd_pend_q <= issue;
         if (issue) rd_last_q <= col_end;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
            fifo_last_q[i] <= 1'b0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push_fifo) begin
            fifo_data_q[wr_ptr_q] <= i_buf_rdata;
            fifo_last_q[wr_ptr_q] <= rd_last_q;
            wr_ptr_q              <= !wr_ptr_q;
         end
         if (pop_fifo) rd_ptr_q <= !rd_ptr_q;
         cnt_q <= cnt_q + {1'b0, push_fifo} - {1'b0, pop_fifo};
      end
   end

   assign o_busy       = (state_q != S_IDLE);
   assign o_done       = done_q;
   assign o_buf_ren    = issue;
   assign o_buf_raddr  = issue ? (row_base_q + AddrWd'(col_q)) : '0;
   assign o_ipix_valid = valid;
   assign o_ipix_wdata = valid ? head_data : '0;
   assign o_ipix_last  = valid && head_last;

endmodule

// File: tb/tb_if_row_sender.sv
// Directed bench for if_row_sender: SRAM model returns {gen, addr}, every transfer is
// checked for address order, beat data/last, handshake hold, latency and done timing.
module tb_if_row_sender;

   logic        i_clk;
   logic        i_rst;
   logic        i_start;
   logic [9:0]  i_base;
   logic [9:0]  i_stride;
   logic [3:0]  i_iflen;
   logic [7:0]  i_nrow;
   logic        o_busy;
   logic        o_done;
   logic        o_buf_ren;
   logic [9:0]  o_buf_raddr;
   logic [15:0] i_buf_rdata;
   logic [15:0] o_ipix_wdata;
   logic        o_ipix_valid;
   logic        i_ipix_ready;
   logic        o_ipix_last;

   logic [5:0]  gen;
   int          n_vec;
   int          n_err;

   if_row_sender dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .i_base       (i_base),
      .i_stride     (i_stride),
      .i_iflen      (i_iflen),
      .i_nrow       (i_nrow),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_buf_ren    (o_buf_ren),
      .o_buf_raddr  (o_buf_raddr),
      .i_buf_rdata  (i_buf_rdata),
      .o_ipix_wdata (o_ipix_wdata),
      .o_ipix_valid (o_ipix_valid),
      .i_ipix_ready (i_ipix_ready),
      .o_ipix_last  (o_ipix_last)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = !i_clk;

   initial i_buf_rdata = '0;
   always @(posedge i_clk) if (o_buf_ren) i_buf_rdata <= {gen, o_buf_raddr};

   task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk_vec({tag, "_busy"},  32'(o_busy),       0);
      chk_vec({tag, "_done"},  32'(o_done),       0);
      chk_vec({tag, "_ren"},   32'(o_buf_ren),    0);
      chk_vec({tag, "_raddr"}, 32'(o_buf_raddr),  0);
      chk_vec({tag, "_valid"}, 32'(o_ipix_valid), 0);
      chk_vec({tag, "_wdata"}, 32'(o_ipix_wdata), 0);
      chk_vec({tag, "_last"},  32'(o_ipix_last),  0);
   endtask

   // mode 0: ready always 1; mode 1: ready 1,0,1,0..; mode 2: ready 0 for cycles 1..10
   task automatic run_xfer(input logic [9:0] base, input logic [9:0] stride,
                           input logic [3:0] iflen, input logic [7:0] nrow,
                           input int mode, input string tag);
      logic [9:0]  exp_a[$];
      logic [16:0] exp_b[$];
      logic [9:0]  got_a[$];
      int          got_rc[$];
      logic [16:0] got_b[$];
      logic [9:0]  rb;
      logic [9:0]  a;
      logic [16:0] prev_b;
      logic        prev_v;
      logic        prev_r;
      int          cyc;
      int          first_v;
      int          last_acc;
      int          done_cyc;
      int          n_ren10;

      rb = base;
      for (int r = 0; r < int'(nrow); r++) begin
         for (int c = 0; c < int'(iflen); c++) begin
            a = rb + 10'(c);
            exp_a.push_back(a);
            exp_b.push_back({(c == int'(iflen) - 1), gen, a});
         end
         rb = rb + stride;
      end

      i_start  = 1'b1;
      i_base   = base;
      i_stride = stride;
      i_iflen  = iflen;
      i_nrow   = nrow;
      @(posedge i_clk); #1;
      i_start  = 1'b0;
      cyc      = 1;
      first_v  = -1;
      last_acc = -1;
      done_cyc = -1;
      n_ren10  = 0;
      prev_v   = 1'b0;
      prev_r   = 1'b0;
      prev_b   = '0;

      while (cyc <= 200 && done_cyc < 0) begin
         case (mode)
            1:       i_ipix_ready = (cyc % 2) == 1;
            2:       i_ipix_ready = cyc > 10;
            default: i_ipix_ready = 1'b1;
         endcase
         #1;
         if (o_buf_ren) begin
            got_a.push_back(o_buf_raddr);
            got_rc.push_back(cyc);
            if (cyc <= 10) n_ren10++;
         end
         if (prev_v && !prev_r) begin
            chk_vec({tag, "_hold_v"}, 32'(o_ipix_valid), 1);
            chk_vec({tag, "_hold_d"}, 32'({o_ipix_last, o_ipix_wdata}), 32'(prev_b));
         end
         if (o_ipix_valid && first_v < 0) first_v = cyc;
         if (o_ipix_valid && i_ipix_ready) begin
            got_b.push_back({o_ipix_last, o_ipix_wdata});
            last_acc = cyc;
         end
         prev_v = o_ipix_valid;
         prev_r = i_ipix_ready;
         prev_b = {o_ipix_last, o_ipix_wdata};
         if (o_done) begin
            done_cyc = cyc;
            chk_vec({tag, "_busy_at_done"}, 32'(o_busy), 0);
         end else begin
            chk_vec({tag, "_busy"}, 32'(o_busy), 1);
         end
         @(posedge i_clk); #1;
         cyc++;
      end
      i_ipix_ready = 1'b0;

      if (done_cyc < 0) chk_vec({tag, "_timeout"}, 0, 1);
      chk_vec({tag, "_n_addr"}, 32'(got_a.size()), 32'(exp_a.size()));
      chk_vec({tag, "_n_beat"}, 32'(got_b.size()), 32'(exp_b.size()));
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
         chk_vec({tag, "_addr"}, 32'(got_a[i]), 32'(exp_a[i]));
      for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
         chk_vec({tag, "_beat"}, 32'(got_b[i]), 32'(exp_b[i]));
      chk_vec({tag, "_first_valid"}, 32'(first_v), 2);
      chk_vec({tag, "_first_ren"}, (got_rc.size() > 0) ? 32'(got_rc[0]) : 0, 1);
      chk_vec({tag, "_done_lat"}, 32'(done_cyc), 32'(last_acc + 1));
      if (mode == 0)
         for (int i = 0; i < got_rc.size(); i++)
            chk_vec({tag, "_ren_cyc"}, 32'(got_rc[i]), 32'(i + 1));
      if (mode == 2) chk_vec({tag, "_ren_stalled"}, 32'(n_ren10), 2);
   endtask

   initial begin
      n_vec        = 0;
      n_err        = 0;
      gen          = 6'h05;
      i_rst        = 1'b1;
      i_start      = 1'b0;
      i_base       = '0;
      i_stride     = '0;
      i_iflen      = '0;
      i_nrow       = '0;
      i_ipix_ready = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      check_all_zero("rst");
      i_rst = 1'b0;
      @(posedge i_clk); #1;

      run_xfer(10'h010, 10'h020, 4'd4, 8'd2, 0, "t1");
      gen = 6'h0A;
      run_xfer(10'h010, 10'h020, 4'd4, 8'd2, 1, "t2");
      gen = 6'h11;
      run_xfer(10'h040, 10'h008, 4'd3, 8'd2, 2, "t3");
      gen = 6'h22;
      run_xfer(10'h3FE, 10'h3FF, 4'd3, 8'd2, 0, "t4");

      // zero-length row: no reads, busy for one cycle, start while busy ignored
      i_start = 1'b1;
      i_base  = 10'h050;
      i_iflen = 4'd0;
      i_nrow  = 8'd3;
      @(posedge i_clk); #1;
      i_iflen = 4'd4;
      i_nrow  = 8'd1;
      #1;
      chk_vec("t5_busy", 32'(o_busy), 1);
      chk_vec("t5_ren",  32'(o_buf_ren), 0);
      chk_vec("t5_done_early", 32'(o_done), 0);
      @(posedge i_clk); #1;
      i_start = 1'b0;
      #1;
      chk_vec("t5_done", 32'(o_done), 1);
      chk_vec("t5_busy_low", 32'(o_busy), 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge i_clk); #2;
         chk_vec("t5_ignored_ren",  32'(o_buf_ren), 0);
         chk_vec("t5_ignored_busy", 32'(o_busy), 0);
      end
      #(-0);

      // reset mid-row with a read outstanding, then a fresh transfer
      gen          = 6'h01;
      i_ipix_ready = 1'b0;
      @(posedge i_clk); #1;
      i_start  = 1'b1;
      i_base   = 10'h100;
      i_stride = 10'h010;
      i_iflen  = 4'd4;
      i_nrow   = 8'd2;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      @(posedge i_clk); #1;
      chk_vec("t6_pre_valid", 32'(o_ipix_valid), 1);
      i_rst = 1'b1;
      #1;
      check_all_zero("t6_rst");
      @(posedge i_clk); #1;
      check_all_zero("t6_rst_edge");
      i_rst = 1'b0;
      gen   = 6'h02;
      @(posedge i_clk); #1;
      run_xfer(10'h200, 10'h010, 4'd3, 8'd2, 0, "t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
